slam_status_capture: RTL and testbench
======================================

// Module: slam_status_capture
// PURPOSE
//  Avalon-MM slave on the HPS lightweight bridge; the inbound counterpart of the LED/ready-signal
//  export peripheral. Samples FPGA-side status lines, synchronizes them, latches sticky edge flags,
//  counts events on bit 0 and raises a maskable level interrupt so HPS software can poll or be
//  interrupted instead of only driving outputs.
// PARAMETERS
//  WIDTH        5   number of status input lines (1..32)
//  SYNC_STAGES  2   synchronizer flops per input (2..4)
//  CNT_WIDTH    16  width of bit-0 event counter (1..32)
// PORTS
//  clk         in   1          system clock (same domain as the Avalon slave)
//  reset_n     in   1          synchronous, active-low reset
//  address     in   2          word address: 0 DATA, 1 EDGE, 2 MASK, 3 COUNT
//  read        in   1          Avalon read strobe
//  write       in   1          Avalon write strobe
//  writedata   in   32         write data
//  readdata    out  32         read data, valid one cycle after read (readLatency = 1)
//  irq         out  1          level interrupt = |(EDGE & MASK)
//  status_in   in   WIDTH      asynchronous status lines from fabric logic
// BEHAVIOUR
//  - Reset (reset_n low at a clk edge): sync flops, prev, EDGE, MASK, COUNT, readdata, irq all 0;
//    warm-up counter cleared. Applies mid-transaction: a read in flight returns 0, no write lands.
//  - Sync: status_in passes SYNC_STAGES flops -> s; DATA = s, zero-extended to 32 bits.
//  - Warm-up: after reset release, edge detection is gated off for SYNC_STAGES+1 cycles (counter
//    saturates at that value); during warm-up prev tracks s, so lines already high at boot cause
//    no edge, no count, no irq.
//  - Edge detect (after warm-up): rise[i] = s[i] & ~prev[i]; prev <= s every cycle.
//    Input change -> DATA visible after SYNC_STAGES cycles -> EDGE bit set one cycle later.
//  - EDGE: sticky; set by detected edge; cleared by write addr 1 with writedata bit = 1 (W1C).
//    Same-cycle edge and W1C on one bit -> bit stays 1 (set wins). Reads never clear.
//  - MASK: RW, WIDTH bits; upper readdata bits 0.
//  - COUNT: +1 per rise[0]; wraps 2^CNT_WIDTH-1 -> 0. Any write to addr 3 clears it;
//    same-cycle clear and rise[0] -> COUNT = 1.
//  - Writes to addr 0 ignored. read and write asserted together: both performed, read returns
//    pre-write value.
//  - readdata registered; holds last value when read low.
//  - irq registered: irq = |(EDGE & MASK) using this-cycle register values, so one cycle after
//    EDGE/MASK update; deasserts one cycle after the last masked bit clears.
// CONFIGURATION
//  STATUS_FALL_EDGE_EN defined: edge = s ^ prev (rising and falling) sets EDGE; COUNT still counts
//    rising edges of bit 0 only.
//  Not defined: EDGE set on rising edges only; falling transitions change DATA only.
// TESTING
//  1 status_in=5'h03 held through reset release -> after warm-up DATA=0x03, EDGE=0, COUNT=0, irq=0.
//  2 MASK=0x04, pulse status_in[2] 0->1 -> EDGE=0x04 at SYNC_STAGES+1 cycles, irq=1 next cycle;
//    write 0x04 to addr 1 -> EDGE=0, irq=0 one cycle later.
//  3 W1C of bit 1 in the same cycle its new rising edge is detected -> EDGE[1] remains 1.
//  4 CNT_WIDTH=4, 17 rising pulses on bit 0 -> COUNT=1 (wrap); write addr 3 coincident with a
//    rise -> COUNT=1.
//  5 Falling edge on bit 3 -> EDGE[3]=1 with STATUS_FALL_EDGE_EN, EDGE[3]=0 without it.
//  6 reset_n low for one cycle during a read with EDGE=0x1F -> readdata=0, EDGE=0, irq=0, warm-up reruns.

Source files
------------

// File: rtl/slam_status_capture.sv
// Avalon-MM status capture: synchronized inputs, sticky W1C edge flags, bit-0 event counter, masked irq.
// Define STATUS_FALL_EDGE_EN to also flag falling transitions in EDGE.
module slam_status_capture #(
    parameter int WIDTH       = 5,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             read,
    input  logic             write,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic             irq,
    input  logic [WIDTH-1:0] status_in
);

    localparam int WARM = SYNC_STAGES + 1;
    localparam int WW   = $clog2(WARM + 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]     s;
    logic [WIDTH-1:0]     prev_q;
    logic [WIDTH-1:0]     edge_q;
    logic [WIDTH-1:0]     mask_q;
    logic [WIDTH-1:0]     rise;
    logic [WIDTH-1:0]     det;
    logic [WIDTH-1:0]     clr;
    logic [CNT_WIDTH-1:0] count_q;
    logic [WW-1:0]        warm_q;
    logic [31:0]          rd_mux;
    logic                 armed;
    logic                 wr_edge;
    logic                 wr_mask;
    logic                 wr_count;
    logic                 unused_wd;

    assign s         = sync_q[SYNC_STAGES-1];
    assign armed     = (warm_q == WW'(WARM));
    assign wr_edge   = write && (address == 2'd1);
    assign wr_mask   = write && (address == 2'd2);
    assign wr_count  = write && (address == 2'd3);
    assign unused_wd = ^writedata;

    // Gate detection until prev has caught up with the synchronizer after reset.
    always_comb begin
        rise = '0;
        det  = '0;
        clr  = '0;
        if (armed) begin
            rise = s & ~prev_q;
`ifdef STATUS_FALL_EDGE_EN
            det  = s ^ prev_q;
`else
            det  = s & ~prev_q;
`endif
        end
        if (wr_edge)
            clr = writedata[WIDTH-1:0];
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: rd_mux[WIDTH-1:0]     = s;
            2'd1: rd_mux[WIDTH-1:0]     = edge_q;
            2'd2: rd_mux[WIDTH-1:0]     = mask_q;
            2'd3: rd_mux[CNT_WIDTH-1:0] = count_q;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q   <= '0;
            prev_q   <= '0;
            warm_q   <= '0;
            edge_q   <= '0;
            mask_q   <= '0;
            count_q  <= '0;
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], status_in};
            prev_q <= s;
            if (!armed)
                warm_q <= warm_q + WW'(1);

            // Set wins over a same-cycle clear on the same bit.
            edge_q <= (edge_q & ~clr) | det;

            if (wr_mask)
                mask_q <= writedata[WIDTH-1:0];

            if (wr_count)
                count_q <= rise[0] ? CNT_WIDTH'(1) : '0;
            else if (rise[0])
                count_q <= count_q + CNT_WIDTH'(1);

            if (read)
                readdata <= rd_mux;

            irq <= |(edge_q & mask_q);
        end
    end

endmodule

// File: tb/tb_slam_status_capture.sv
// Self-checking bench for slam_status_capture: directed boundary cases plus randomized
// status sequences scored against an event-level model of edges and bit-0 rises.
module tb_slam_status_capture;

    localparam int W    = 5;
    localparam int SYNC = 2;
    localparam int CW   = 4;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic [W-1:0] status_in;

    int checks = 0;
    int errors = 0;

    slam_status_capture #(.WIDTH(W), .SYNC_STAGES(SYNC), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .read      (read),
        .write     (write),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq),
        .status_in (status_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    logic [31:0] rd;
    logic [W-1:0] v, pv, rises, falls, exp_edge, msk;
    int cnt;

    initial begin
        reset_n = 1'b0; address = '0; read = 1'b0; write = 1'b0; writedata = '0;
        status_in = 5'h03;
        tick(3);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'h0, irq}, 32'h0);

        // lines high through reset release must not produce edges
        reset_n = 1'b1;
        tick(SYNC + 4);
        bus_read(2'd0, rd); chk("boot_data", rd, 32'h03);
        bus_read(2'd1, rd); chk("boot_edge", rd, 32'h0);
        bus_read(2'd3, rd); chk("boot_count", rd, 32'h0);
        chk("boot_irq", {31'h0, irq}, 32'h0);

        // masked rise on bit 2, then W1C
        bus_write(2'd2, 32'h04);
        bus_read(2'd2, rd); chk("mask_rw", rd, 32'h04);
        status_in = 5'h07;
        tick(SYNC + 1);
        chk("irq_before", {31'h0, irq}, 32'h0);
        tick(1);
        chk("irq_set", {31'h0, irq}, 32'h1);
        bus_read(2'd1, rd); chk("edge_bit2", rd, 32'h04);
        tick(3);
        chk("readdata_hold", readdata, 32'h04);
        bus_write(2'd1, 32'h04);
        chk("irq_lag", {31'h0, irq}, 32'h1);
        tick(1);
        chk("irq_clear", {31'h0, irq}, 32'h0);
        bus_read(2'd1, rd); chk("edge_w1c", rd, 32'h0);

        // W1C coincident with new rise on bit 1
        status_in = 5'h05;
        tick(SYNC + 3);
        bus_write(2'd1, 32'h1F);
        tick(2);
        status_in = 5'h07;
        tick(SYNC);
        bus_write(2'd1, 32'h02);
        bus_read(2'd1, rd); chk("edge_set_wins", rd, 32'h02);

        // addr 0 writes ignored; simultaneous read+write returns old value
        bus_write(2'd0, 32'hFFFF_FFFF);
        bus_read(2'd0, rd); chk("data_ro", rd, 32'h07);
        address = 2'd2; writedata = 32'h0B; write = 1'b1; read = 1'b1;
        @(negedge clk);
        write = 1'b0; read = 1'b0;
        chk("rw_old", readdata, 32'h04);
        bus_read(2'd2, rd); chk("rw_new", rd, 32'h0B);

        // counter wrap with CNT_WIDTH=4
        status_in = 5'h06;
        tick(SYNC + 3);
        bus_write(2'd3, 32'h0);
        for (int i = 0; i < 17; i++) begin
            status_in = 5'h07; tick($urandom_range(1, 3));
            status_in = 5'h06; tick($urandom_range(1, 3));
        end
        tick(SYNC + 3);
        bus_read(2'd3, rd); chk("count_wrap", rd, 32'h1);
        status_in = 5'h07;
        tick(SYNC);
        bus_write(2'd3, 32'h0);
        bus_read(2'd3, rd); chk("count_clr_rise", rd, 32'h1);

        // falling edge on bit 3
        status_in = 5'h0F;
        tick(SYNC + 3);
        bus_write(2'd1, 32'h1F);
        status_in = 5'h07;
        tick(SYNC + 3);
        bus_read(2'd1, rd);
`ifdef STATUS_FALL_EDGE_EN
        chk("fall_edge", rd, 32'h08);
`else
        chk("fall_edge", rd, 32'h00);
`endif

        // randomized rounds against an event-level model
        for (int r = 0; r < 4; r++) begin
            msk = W'($urandom_range(0, 31));
            bus_write(2'd2, {27'h0, msk});
            tick(SYNC + 3);
            bus_write(2'd1, 32'h1F);
            bus_write(2'd3, 32'h0);
            tick(1);
            pv = status_in; rises = '0; falls = '0; cnt = 0;
            for (int k = 0; k < 20; k++) begin
                v = W'($urandom_range(0, 31));
                status_in = v;
                rises |= v & ~pv;
                falls |= ~v & pv;
                if (v[0] && !pv[0]) cnt++;
                pv = v;
                tick($urandom_range(1, 3));
            end
            tick(SYNC + 3);
`ifdef STATUS_FALL_EDGE_EN
            exp_edge = rises | falls;
`else
            exp_edge = rises;
`endif
            bus_read(2'd1, rd); chk($sformatf("rnd%0d_edge", r), rd, {27'h0, exp_edge});
            bus_read(2'd3, rd); chk($sformatf("rnd%0d_count", r), rd, 32'(cnt % (1 << CW)));
            bus_read(2'd0, rd); chk($sformatf("rnd%0d_data", r), rd, {27'h0, pv});
            chk($sformatf("rnd%0d_irq", r), {31'h0, irq}, {31'h0, |(exp_edge & msk)});
        end

        // reset pulse during a read with all edges pending
        bus_write(2'd2, 32'h1F);
        status_in = 5'h00;
        tick(SYNC + 3);
        bus_write(2'd1, 32'h1F);
        status_in = 5'h1F;
        tick(SYNC + 3);
        chk("pre_rst_irq", {31'h0, irq}, 32'h1);
        bus_read(2'd1, rd); chk("pre_rst_edge", rd, 32'h1F);
        address = 2'd1; read = 1'b1; reset_n = 1'b0;
        @(negedge clk);
        read = 1'b0; reset_n = 1'b1;
        chk("rst_readdata", readdata, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        tick(SYNC + 4);
        bus_read(2'd1, rd); chk("rst_edge", rd, 32'h0);
        bus_read(2'd2, rd); chk("rst_mask", rd, 32'h0);
        bus_read(2'd3, rd); chk("rst_count", rd, 32'h0);
        bus_read(2'd0, rd); chk("rst_data", rd, 32'h1F);
        chk("rst_irq_late", {31'h0, irq}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
